// File: rtl/fila_bytes.sv
// fila_bytes: byte queue sitting right after the serial-to-byte deserializer.
// Bytes arrive through a level ready / ack handshake and are stored in a
// circular buffer. They leave one per dequeue request, each with a one-cycle
// valid pulse.
// Optional build macro FILA_STALL_CNT_EN adds stall_cnt_out, a saturating
// count of cycles in which a byte was waiting but the queue was full.
module fila_bytes #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk_100KHz,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       data_ready_in,
    output logic                       ack_out,
    input  logic                       dequeue_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       valid_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       full_out,
`ifdef FILA_STALL_CNT_EN
    output logic                       empty_out,
    output logic [7:0]                 stall_cnt_out
`else
    output logic                       empty_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(DEPTH+1);

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wr_state_t;

    wr_state_t        state;
    wr_state_t        state_next;
    logic             write_en;
    logic             pop_en;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Flags come straight from the registered count, so a write and a pop in
    // the same cycle are both judged on the occupancy before that edge.
    assign full_out  = (len_out == LEN_W'(DEPTH));
    assign empty_out = (len_out == '0);
    assign pop_en    = dequeue_in && !empty_out;

    // Write FSM state register; reset drops any handshake in progress.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state <= W_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one capture per ready assertion, then wait for ready to fall.
    always_comb begin
        state_next = state;
        case (state)
            W_IDLE: begin
                if (data_ready_in && !full_out) begin
                    state_next = W_ACK;
                end
            end
            W_ACK: begin
                if (!data_ready_in) begin
                    state_next = W_IDLE;
                end
            end
            default: state_next = W_IDLE;
        endcase
    end

    // Output logic: ack is high exactly while in W_ACK; the write strobe fires on the capture edge.
    always_comb begin
        ack_out  = 1'b0;
        write_en = 1'b0;
        case (state)
            W_IDLE: write_en = data_ready_in && !full_out;
            W_ACK:  ack_out  = 1'b1;
            default: begin
                ack_out  = 1'b0;
                write_en = 1'b0;
            end
        endcase
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_100KHz) begin
        if (write_en) begin
            mem[tail_ptr] <= data_in;
        end
    end

    // Head/tail pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (write_en) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy counter; a simultaneous write and pop leaves it unchanged.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            len_out <= '0;
        end else begin
            case ({write_en, pop_en})
                2'b10:   len_out <= len_out + LEN_W'(1);
                2'b01:   len_out <= len_out - LEN_W'(1);
                default: len_out <= len_out;
            endcase
        end
    end

    // Read port: popped byte is registered with a single-cycle valid pulse; an empty read keeps data_out.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_en;
            if (pop_en) begin
                data_out <= mem[head_ptr];
            end
        end
    end

`ifdef FILA_STALL_CNT_EN
    // Stall counter: cycles where the deserializer offers a byte but the queue is full.
    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            stall_cnt_out <= '0;
        end else if ((state == W_IDLE) && data_ready_in && full_out
                     && (stall_cnt_out != 8'hFF)) begin
            stall_cnt_out <= stall_cnt_out + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fila_bytes.sv
// tb_fila_bytes: directed testbench for fila_bytes with hand-computed
// expectations. Stall counter checks are compiled in only when
// FILA_STALL_CNT_EN is defined.
module tb_fila_bytes;

    logic       clk_100KHz;
    logic       reset;
    logic [7:0] data_in;
    logic       data_ready_in;
    logic       ack_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;
`ifdef FILA_STALL_CNT_EN
    logic [7:0] stall_cnt_out;
`endif

    int check_count;
    int pass_count;

    fila_bytes #(.DEPTH(8), .WIDTH(8)) dut (
        .clk_100KHz    (clk_100KHz),
        .reset         (reset),
        .data_in       (data_in),
        .data_ready_in (data_ready_in),
        .ack_out       (ack_out),
        .dequeue_in    (dequeue_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .len_out       (len_out),
        .full_out      (full_out),
`ifdef FILA_STALL_CNT_EN
        .empty_out     (empty_out),
        .stall_cnt_out (stall_cnt_out)
`else
        .empty_out     (empty_out)
`endif
    );

    // Free-running clock
    initial clk_100KHz = 1'b0;
    always #5 clk_100KHz = ~clk_100KHz;

    // Single comparison point: count it and report any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic applyStimulus(input logic rdy, input logic [7:0] d, input logic deq);
        data_ready_in = rdy;
        data_in       = d;
        dequeue_in    = deq;
        @(posedge clk_100KHz);
        #1;
    endtask

    // Full handshake for one byte: capture edge, then release edge
    task automatic pushByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0);
        checkOutput("push_ack", 32'(ack_out), 32'd1);
        applyStimulus(1'b0, b, 1'b0);
    endtask

    // Single pop with check of the returned byte and valid pulse
    task automatic popByte(input string tag, input logic [7:0] exp_b);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput(tag, 32'(data_out), 32'(exp_b));
        checkOutput("pop_valid", 32'(valid_out), 32'd1);
    endtask

    initial begin
        check_count   = 0;
        pass_count    = 0;
        reset         = 1'b1;
        data_in       = 8'h00;
        data_ready_in = 1'b0;
        dequeue_in    = 1'b0;
        repeat (2) @(posedge clk_100KHz);
        #1;
        checkOutput("rst_ack",   32'(ack_out),   32'd0);
        checkOutput("rst_empty", 32'(empty_out), 32'd1);
        checkOutput("rst_full",  32'(full_out),  32'd0);
        checkOutput("rst_len",   32'(len_out),   32'd0);
        checkOutput("rst_valid", 32'(valid_out), 32'd0);
        checkOutput("rst_data",  32'(data_out),  32'd0);
        #2 reset = 1'b0;

        // Idle cycles leave everything at rest
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("idle_ack", 32'(ack_out), 32'd0);
        checkOutput("idle_len", 32'(len_out), 32'd0);

        // Handshake: ready held for 3 edges gives exactly one write
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("hs_ack_e1", 32'(ack_out), 32'd1);
        checkOutput("hs_len_e1", 32'(len_out), 32'd1);
        applyStimulus(1'b1, 8'hA5, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b0);
        checkOutput("hs_ack_e3", 32'(ack_out), 32'd1);
        checkOutput("hs_len_e3", 32'(len_out), 32'd1);
        data_ready_in = 1'b0;
        #1;
        checkOutput("hs_ack_drop_cycle", 32'(ack_out), 32'd1);
        applyStimulus(1'b0, 8'hA5, 1'b0);
        checkOutput("hs_ack_release", 32'(ack_out), 32'd0);
        checkOutput("hs_len_single", 32'(len_out), 32'd1);
        popByte("hs_pop_data", 8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("hs_valid_pulse", 32'(valid_out), 32'd0);
        checkOutput("hs_empty", 32'(empty_out), 32'd1);

        // Fill to capacity
        for (int i = 1; i <= 8; i++) begin
            pushByte(8'(i));
        end
        checkOutput("fill_full", 32'(full_out), 32'd1);
        checkOutput("fill_len",  32'(len_out),  32'd8);

        // 9th byte held while full: no ack, no write
        applyStimulus(1'b1, 8'h09, 1'b0);
        applyStimulus(1'b1, 8'h09, 1'b0);
        checkOutput("full_no_ack", 32'(ack_out), 32'd0);
        checkOutput("full_len",    32'(len_out), 32'd8);
`ifdef FILA_STALL_CNT_EN
        checkOutput("stall_cnt_2", 32'(stall_cnt_out), 32'd2);
`endif
        // Pop while full: write still refused this edge
        applyStimulus(1'b1, 8'h09, 1'b1);
        checkOutput("full_pop_data", 32'(data_out),  32'h01);
        checkOutput("full_pop_vld",  32'(valid_out), 32'd1);
        checkOutput("full_pop_ack",  32'(ack_out),   32'd0);
        checkOutput("full_pop_len",  32'(len_out),   32'd7);
`ifdef FILA_STALL_CNT_EN
        checkOutput("stall_cnt_3", 32'(stall_cnt_out), 32'd3);
`endif
        applyStimulus(1'b1, 8'h09, 1'b0);
        checkOutput("late_ack", 32'(ack_out), 32'd1);
        checkOutput("late_len", 32'(len_out), 32'd8);
`ifdef FILA_STALL_CNT_EN
        checkOutput("stall_cnt_hold", 32'(stall_cnt_out), 32'd3);
`endif
        applyStimulus(1'b0, 8'h09, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            popByte("drain_data", 8'(i));
        end
        checkOutput("drain_empty", 32'(empty_out), 32'd1);

        // Wrap: push 6 / pop 6 / push 5 / pop 5 crosses the pointer wrap
        for (int i = 0; i < 6; i++) pushByte(8'h10 + 8'(i));
        for (int i = 0; i < 6; i++) popByte("wrap1_data", 8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) pushByte(8'h20 + 8'(i));
        checkOutput("wrap_len5", 32'(len_out), 32'd5);
        for (int i = 0; i < 5; i++) popByte("wrap2_data", 8'h20 + 8'(i));
        checkOutput("wrap_empty", 32'(empty_out), 32'd1);

        // Simultaneous push and pop at len 3
        pushByte(8'h30);
        pushByte(8'h31);
        pushByte(8'h32);
        applyStimulus(1'b1, 8'h33, 1'b1);
        checkOutput("pp_len",  32'(len_out),   32'd3);
        checkOutput("pp_data", 32'(data_out),  32'h30);
        checkOutput("pp_ack",  32'(ack_out),   32'd1);
        applyStimulus(1'b0, 8'h33, 1'b0);
        popByte("pp_rest", 8'h31);
        popByte("pp_rest", 8'h32);
        popByte("pp_rest", 8'h33);

        // Dequeue on empty is ignored
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("empty_rd_valid", 32'(valid_out), 32'd0);
        checkOutput("empty_rd_data",  32'(data_out),  32'h33);
        checkOutput("empty_rd_len",   32'(len_out),   32'd0);

        // Reset during W_ACK clears queue and ack at once
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("ra_ack_before", 32'(ack_out), 32'd1);
        #1 reset = 1'b1;
        #1;
        checkOutput("ra_ack_now", 32'(ack_out), 32'd0);
        checkOutput("ra_len_now", 32'(len_out), 32'd0);
        checkOutput("ra_empty",   32'(empty_out), 32'd1);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 8'h44, 1'b0);
        checkOutput("ra_reaccept_ack", 32'(ack_out), 32'd1);
        checkOutput("ra_reaccept_len", 32'(len_out), 32'd1);
        applyStimulus(1'b0, 8'h44, 1'b0);
        popByte("ra_pop", 8'h44);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
